// File: rtl/lfsr_noise_gen.sv
// Parametrised Galois LFSR noise source with rate divider, seed reload,
// all-zero lock-up recovery, signed amplitude-scaled sample and wrap detection.
module lfsr_noise_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}},
    parameter int               DIV_W = 8,
    parameter int               OUT_W = 16
) (
    input  logic             clk,
    input  logic             I_RST,
    input  logic             audio_clk_en,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] rate_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [OUT_W-2:0] level_i,
    output logic [WIDTH-1:0] state_o,
    output logic             noise_o,
    output logic [OUT_W-1:0] sample_o,
    output logic             step_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] ZERO_STATE = {WIDTH{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ZERO   = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE    = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0] OUT_ONE    = {{(OUT_W-1){1'b0}}, 1'b1};

    // A zero state never advances in a Galois LFSR, so it is replaced by SEED.
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] n;
        if (s == ZERO_STATE) begin
            n = SEED;
        end else begin
            n = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : ZERO_STATE);
        end
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] seed_fix(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] v;
        if (s == ZERO_STATE) begin
            v = SEED;
        end else begin
            v = s;
        end
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] scale_sample(input logic             noise,
                                                      input logic [OUT_W-2:0] level);
        logic [OUT_W-1:0] mag;
        logic [OUT_W-1:0] res;
        mag = {1'b0, level};
        if (noise) begin
            res = mag;
        end else begin
            res = ~mag + OUT_ONE;
        end
        return res;
    endfunction

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_start;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_noise;
    logic [OUT_W-1:0] r_sample;
    logic             r_step;
    logic             r_wrap;

    logic             w_tick;
    logic             w_div_zero;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_val;
    logic             w_wrap;
    logic [OUT_W-1:0] w_sample;

    // Next-state, load value and wrap detection for the current cycle.
    always_comb begin
        w_tick     = audio_clk_en & enable_i;
        w_div_zero = (r_div_cnt == DIV_ZERO);
        w_next     = lfsr_next(r_state);
        w_load_val = seed_fix(seed_i);
        w_sample   = scale_sample(w_next[WIDTH-1], level_i);
        if (w_next == r_start) begin
            w_wrap = 1'b1;
        end else begin
            w_wrap = 1'b0;
        end
    end

    // Reset > load > divider/step; every output is a register.
    always_ff @(posedge clk) begin
        if (I_RST) begin
            r_state   <= SEED;
            r_start   <= SEED;
            r_div_cnt <= DIV_ZERO;
            r_noise   <= SEED[WIDTH-1];
            r_sample  <= {OUT_W{1'b0}};
            r_step    <= 1'b0;
            r_wrap    <= 1'b0;
        end else if (load_i) begin
            r_state   <= w_load_val;
            r_start   <= w_load_val;
            r_div_cnt <= rate_i;
            r_noise   <= w_load_val[WIDTH-1];
            r_step    <= 1'b0;
            r_wrap    <= 1'b0;
        end else if (w_tick && w_div_zero) begin
            r_state   <= w_next;
            r_div_cnt <= rate_i;
            r_noise   <= w_next[WIDTH-1];
            r_sample  <= w_sample;
            r_step    <= 1'b1;
            r_wrap    <= w_wrap;
        end else if (w_tick) begin
            r_div_cnt <= r_div_cnt - DIV_ONE;
            r_step    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_step    <= 1'b0;
            r_wrap    <= 1'b0;
        end
    end

    assign state_o  = r_state;
    assign noise_o  = r_noise;
    assign sample_o = r_sample;
    assign step_o   = r_step;
    assign wrap_o   = r_wrap;

endmodule

// File: doc/lfsr_noise_gen.md
Name: lfsr_noise_gen

Overview:
Parametrised Galois LFSR noise source for the discrete-sound audio path. It replaces the fixed 8-bit generator with configurable width, tap mask and seed. A programmable rate divider sets the noise pitch, seed reload is synchronous, and all-zero lock-up recovery is built in. It outputs a raw noise bit, a signed amplitude-scaled audio sample, and sequence-wrap detection. It sits between the audio clock-enable generator and the channel mixer.

Parameters:
WIDTH, 8, LFSR length in bits (allowed range 4..32).
TAPS, 8'h1D, Galois feedback mask: bit i set means state[i] receives feedback at step (default polynomial x^8+x^4+x^3+x^2+1).
SEED, all ones, reset/substitute state; must be nonzero.
DIV_W, 8, rate divider width.
OUT_W, 16, signed sample width.

Ports:
clk  in  1  system clock
I_RST  in  1  synchronous reset, active-high
audio_clk_en  in  1  audio-rate clock enable, one clk wide
enable_i  in  1  run gate; 0 freezes divider and LFSR
rate_i  in  DIV_W  divider reload; LFSR steps once per (rate_i+1) qualified enables
load_i  in  1  single-cycle seed load strobe
seed_i  in  WIDTH  value loaded on load_i
level_i  in  OUT_W-1  unsigned amplitude
state_o  out  WIDTH  current LFSR state
noise_o  out  1  registered noise bit
sample_o  out  OUT_W  signed sample
step_o  out  1  one-clk pulse on each LFSR step
wrap_o  out  1  one-clk pulse when state returns to its start value

Behaviour:
- Interface: one clock (clk). Reset I_RST is synchronous and active-high.
- Reset values: state_o=SEED, start register=SEED, div_cnt=0, noise_o=SEED[WIDTH-1], sample_o=0, step_o=0, wrap_o=0.
- Qualified tick: audio_clk_en && enable_i. Other cycles hold all state; step_o and wrap_o are 0.
- Divider on a qualified tick:
  - if div_cnt==0: step, and div_cnt<=rate_i;
  - else div_cnt<=div_cnt-1.
  - rate_i=0 gives a step on every qualified tick. rate_i changes take effect at the next reload.
- Step: next = {state[WIDTH-2:0],1'b0} ^ (state[WIDTH-1] ? TAPS : 0).
- Lock-up guard: if state==0 at a step, next=SEED. Zero is reachable only by a misconfigured TAPS.
- Step side effects, all registered in the same clk as the state update:
  - step_o=1;
  - noise_o=next[WIDTH-1];
  - sample_o = noise ? +level_i : -level_i, in two's complement. level_i is zero-extended to OUT_W bits, and level_i=0 gives 0.
- wrap_o=1 on the step whose next state equals the start register. With default parameters this is every 255 steps.
- load_i is independent of audio_clk_en and enable_i:
  - state<=seed_i, or SEED if seed_i==0;
  - start register gets the same value;
  - div_cnt<=rate_i;
  - noise_o is updated from the loaded state; sample_o holds;
  - step_o and wrap_o are 0 that cycle.
- Priority: I_RST > load_i > step. A load coincident with a step suppresses the step.
- Reset mid-sequence: full return to reset values on the next clk, with no partial step.
- Latency: a state change is visible on state_o one clk after the qualifying edge or load.
- No combinational path from inputs to outputs.

Test Plan:
- Reset with defaults, then continuous qualified ticks at rate_i=0 -> state_o sequence 0xFF, 0xE3, 0xDB, ...; step_o high every tick; noise_o=1,1,1.
- Run 255 steps from reset at rate_i=0 -> wrap_o pulses exactly once, on step 255, when state_o returns to 0xFF; no earlier pulse.
- rate_i=3, audio_clk_en every 4th clk -> one step per 4 enables (16 clks); enable_i=0 mid-run freezes state_o and div_cnt.
- load_i with seed_i=0x00 -> state_o=0xFF next clk; load_i with 0x5A coincident with a step -> state_o=0x5A, step_o=0; wrap_o then fires 255 steps later at 0x5A.
- level_i=0x1234 -> sample_o=0x1234 when noise_o=1, 0xEDCC when noise_o=0; level_i=0 gives 0.
- Assert I_RST for 1 clk mid-run, and separately force TAPS=0 with WIDTH=8 -> all outputs return to reset values; zero-state step yields SEED.
